// File: rtl/jt12_bus_writer_if.sv
// Command and chip-bus bundle for jt12_bus_writer.
//   cmd_valid/cmd_ready : command handshake (accepted when both high)
//   cmd_part            : register bank (0: ports 0/1, 1: ports 2/3)
//   cmd_reg/cmd_data    : register address / value
//   ym_din/ym_addr      : data and address driven to the chip
//   ym_cs_n/ym_wr_n     : active-low chip select / write strobe
//   ym_dout             : chip status, bit 7 = busy
// slave : the writer side; master : the command source / chip model side.
interface jt12_bus_writer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_part;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_data;
  logic [7:0] ym_din;
  logic [1:0] ym_addr;
  logic       ym_cs_n;
  logic       ym_wr_n;
  logic [7:0] ym_dout;

  modport slave (
    input  cmd_valid, cmd_part, cmd_reg, cmd_data, ym_dout,
    output cmd_ready, ym_din, ym_addr, ym_cs_n, ym_wr_n
  );

  modport master (
    output cmd_valid, cmd_part, cmd_reg, cmd_data, ym_dout,
    input  cmd_ready, ym_din, ym_addr, ym_cs_n, ym_wr_n
  );
endinterface

// File: rtl/jt12_bus_writer.sv
// Queued register writer for a YM2612-style bus.
// Commands are buffered in a small FIFO (push independent of cen). Each one
// is issued as an address strobe, a one-cycle gap, a data strobe, a two-cycle
// guard and a busy-wait with timeout. All sequencing advances on cen=1.
//   clk, rst    : clock, asynchronous active-high reset
//   cen         : clock enable for the sequencer
//   bus         : command handshake and chip bus (slave modport)
//   idle        : FIFO empty and sequencer idle
//   level       : FIFO occupancy
//   err_timeout : sticky busy-timeout flag, cleared by err_clr
module jt12_bus_writer #(
  parameter int unsigned STROBE_LEN = 2,
  parameter int unsigned FIFO_AW    = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  jt12_bus_writer_if.slave   bus,
  output logic               idle,
  output logic [FIFO_AW:0]   level,
  output logic               err_timeout,
  input  logic               err_clr
);

  typedef enum logic [2:0] {IDLE, ADDR_STB, GAP, DATA_STB, GUARD, BUSY_WAIT} state_t;

  localparam int unsigned        DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [7:0]         STB_LAST = 8'(STROBE_LEN - 1);
  localparam logic [7:0]         TO_LAST  = 8'(TIMEOUT - 1);

  // FIFO entry layout: {part, reg, data}
  logic [16:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic [16:0]        head;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] work_q, work_d;     // {part, data} of the command in flight
  logic [7:0] din_q, din_d;
  logic [1:0] addr_q, addr_d;
  logic       strobe_n_q, strobe_n_d;
  logic       err_q, err_d;
  logic       push, pop, done, err_set;

  assign bus.cmd_ready = (level_q != LVL_FULL);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign head          = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    din_d      = din_q;
    addr_d     = addr_q;
    strobe_n_d = strobe_n_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pop        = 1'b0;
    done       = 1'b0;
    err_set    = 1'b0;

    if (cen) begin
      case (state_q)
        IDLE: done = 1'b1;
        ADDR_STB: begin
          if (cnt_q == STB_LAST) begin
            state_d    = GAP;
            strobe_n_d = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        GAP: begin
          state_d    = DATA_STB;
          strobe_n_d = 1'b0;
          addr_d     = {work_q[8], 1'b1};
          din_d      = work_q[7:0];
          cnt_d      = '0;
        end
        DATA_STB: begin
          if (cnt_q == STB_LAST) begin
            state_d    = GUARD;
            strobe_n_d = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        GUARD: begin
          if (cnt_q == 8'd1) begin
            state_d = BUSY_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        BUSY_WAIT: begin
          if (!bus.ym_dout[7]) begin
            done = 1'b1;
          end else if (cnt_q == TO_LAST) begin
            err_set = 1'b1;
            done    = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Leaving BUSY_WAIT goes straight into the next address strobe when a
    // command is queued, so back-to-back writes lose no cycle in IDLE.
    if (done) begin
      state_d = IDLE;
      pop     = (level_q != '0);
    end

    if (pop) begin
      state_d    = ADDR_STB;
      work_d     = {head[16], head[7:0]};
      addr_d     = {head[16], 1'b0};
      din_d      = head[15:8];
      strobe_n_d = 1'b0;
      cnt_d      = '0;
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    err_d = err_set || (err_q && !err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      din_q      <= '0;
      addr_q     <= '0;
      strobe_n_q <= 1'b1;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      din_q      <= din_d;
      addr_q     <= addr_d;
      strobe_n_q <= strobe_n_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.cmd_part, bus.cmd_reg, bus.cmd_data};
  end

  // cs_n and wr_n share one flop so they always move together.
  assign bus.ym_cs_n = strobe_n_q;
  assign bus.ym_wr_n = strobe_n_q;
  assign bus.ym_addr = addr_q;
  assign bus.ym_din  = din_q;
  assign level       = level_q;
  assign err_timeout = err_q;
  assign idle        = (level_q == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_jt12_bus_writer.sv
// Directed bench for jt12_bus_writer with default parameters.
module tb_jt12_bus_writer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       err_clr = 1'b0;
  logic       idle;
  logic [2:0] level;
  logic       err_timeout;

  jt12_bus_writer_if bus_if();

  jt12_bus_writer #(.STROBE_LEN(2), .FIFO_AW(2), .TIMEOUT(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .cen         (cen),
    .bus         (bus_if.slave),
    .idle        (idle),
    .level       (level),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: records {addr, din} and low length (clk cycles) per strobe.
  logic [9:0] wq[$];
  int         lq[$];
  logic [9:0] cur_entry = '0;
  int         cur_len = 0;
  logic       prev_cs = 1'b1;
  int         pair_err = 0;

  always @(negedge clk) begin
    if (bus_if.ym_cs_n !== bus_if.ym_wr_n) pair_err++;
    if (bus_if.ym_cs_n === 1'b0) begin
      if (prev_cs) begin
        cur_entry = {bus_if.ym_addr, bus_if.ym_din};
        cur_len   = 0;
      end
      cur_len++;
    end else if (!prev_cs) begin
      wq.push_back(cur_entry);
      lq.push_back(cur_len);
    end
    prev_cs = bus_if.ym_cs_n;
  end

  function automatic logic [9:0] wq_at(input int i);
    return (i < wq.size()) ? wq[i] : 10'h3ff;
  endfunction

  function automatic int lq_at(input int i);
    return (i < lq.size()) ? lq[i] : -1;
  endfunction

  task automatic clear_mon();
    wq.delete();
    lq.delete();
  endtask

  task automatic push(input logic p, input logic [7:0] r, input logic [7:0] d);
    bus_if.cmd_part  = p;
    bus_if.cmd_reg   = r;
    bus_if.cmd_data  = d;
    bus_if.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input bit tog);
    int n = 0;
    while (n < max_cyc) begin
      @(posedge clk);
      #1;
      if (tog) cen = ~cen;
      if (idle === 1'b1) break;
      n++;
    end
    cen = 1'b1;
    check("idle_wait", idle, 1);
  endtask

  logic [8:0] exp_cs   = 9'b111100100;
  logic [8:0] exp_a0   = 9'b111111000;
  logic [8:0] exp_idle = 9'b100000000;

  initial begin
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_part  = 1'b0;
    bus_if.cmd_reg   = '0;
    bus_if.cmd_data  = '0;
    bus_if.ym_dout   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cs_n", bus_if.ym_cs_n, 1);
    check("rst_wr_n", bus_if.ym_wr_n, 1);
    check("rst_addr", bus_if.ym_addr, 0);
    check("rst_din", bus_if.ym_din, 0);
    check("rst_level", level, 0);
    check("rst_ready", bus_if.cmd_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_err", err_timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single write, part 0: cycle-by-cycle sequence
    clear_mon();
    push(1'b0, 8'h28, 8'hF0);
    @(negedge clk);
    check("t1_level0", level, 1);
    check("t1_cs0", bus_if.ym_cs_n, 1);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check($sformatf("t1_cs_c%0d", k + 1), bus_if.ym_cs_n, exp_cs[k]);
      check($sformatf("t1_a_c%0d", k + 1), bus_if.ym_addr, {1'b0, exp_a0[k]});
      check($sformatf("t1_din_c%0d", k + 1), bus_if.ym_din, (k < 3) ? 8'h28 : 8'hF0);
      check($sformatf("t1_idle_c%0d", k + 1), idle, exp_idle[k]);
    end

    // Part 1 write: addresses 2 then 3, strobes 2 clk each at cen=1
    clear_mon();
    push(1'b1, 8'h30, 8'h71);
    wait_idle(100, 1'b0);
    check("t2_count", wq.size(), 2);
    check("t2_w0", wq_at(0), {2'd2, 8'h30});
    check("t2_w1", wq_at(1), {2'd3, 8'h71});
    check("t2_len0", lq_at(0), 2);
    check("t2_len1", lq_at(1), 2);

    // Fill FIFO while busy, then drain in order
    clear_mon();
    bus_if.ym_dout = 8'h80;
    for (int i = 0; i < 5; i++) push(i[0], 8'h40 + 8'(i), 8'hA0 + 8'(i));
    check("t3_level_full", level, 4);
    check("t3_ready_full", bus_if.cmd_ready, 0);
    repeat (20) @(posedge clk);
    #1;
    check("t3_level_hold", level, 4);
    check("t3_ready_hold", bus_if.cmd_ready, 0);
    bus_if.ym_dout = 8'h00;
    wait_idle(400, 1'b0);
    check("t3_count", wq.size(), 10);
    for (int j = 0; j < 10; j++) begin
      int c;
      c = j / 2;
      check($sformatf("t3_w%0d", j), wq_at(j),
            {c[0], j[0], (j[0] ? 8'hA0 : 8'h40) + 8'(c)});
    end
    check("t3_err", err_timeout, 0);

    // Busy stuck high: timeout after 255 BUSY_WAIT cycles, then clear
    bus_if.ym_dout = 8'h80;
    push(1'b0, 8'h22, 8'h08);
    repeat (262) @(posedge clk);
    @(negedge clk);
    check("t4_err_before", err_timeout, 0);
    check("t4_idle_before", idle, 0);
    @(negedge clk);
    check("t4_err_set", err_timeout, 1);
    check("t4_idle_after", idle, 1);
    @(negedge clk);
    check("t4_err_sticky", err_timeout, 1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("t4_err_clr", err_timeout, 0);
    bus_if.ym_dout = 8'h00;

    // cen toggling: strobes stretch to 4 clk
    clear_mon();
    @(negedge clk);
    push(1'b1, 8'hA4, 8'h5C);
    wait_idle(200, 1'b1);
    check("t5_count", wq.size(), 2);
    check("t5_w0", wq_at(0), {2'd2, 8'hA4});
    check("t5_w1", wq_at(1), {2'd3, 8'h5C});
    check("t5_len0", lq_at(0), 4);
    check("t5_len1", lq_at(1), 4);

    // Reset during data strobe with 3 commands queued
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(1'b0, 8'h50 + 8'(i), 8'h10 + 8'(i));
    check("t6_level", level, 3);
    @(posedge clk);
    #1;
    check("t6_in_data_cs", bus_if.ym_cs_n, 0);
    check("t6_in_data_addr", bus_if.ym_addr, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_cs_n", bus_if.ym_cs_n, 1);
    check("t6_rst_wr_n", bus_if.ym_wr_n, 1);
    check("t6_rst_level", level, 0);
    check("t6_rst_ready", bus_if.cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_mon();
    repeat (40) @(negedge clk);
    check("t6_no_writes", wq.size(), 0);
    check("t6_idle", idle, 1);
    check("t6_cs_n", bus_if.ym_cs_n, 1);

    check("cs_wr_paired", pair_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
